pc_fetch_ctrl: RTL and testbench

//   Sequences the program counter and the instruction-fetch handshake.
//   - Holds the PC and issues one fetch request per instruction.
//   - Advances the PC on each completed fetch; applies branch redirects, stalls and run/halt.
//   - Sits between the core control unit (run/stall/branch) and the instruction memory port.

---
 rtl/pc_fetch_ctrl_pkg.sv | 27 ++
 rtl/pc_fetch_ctrl_if.sv | 26 ++
 rtl/pc_fetch_ctrl_next_sel.sv | 21 ++
 rtl/pc_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the PC / instruction-fetch sequencer.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam int unsigned DEF_PC_W     = 8;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_STEP     = 1;

    // Run/stall decode shared by IDLE, HOLD and the REQ ack cycle.
    function automatic fetch_state_e run_state(input logic run, input logic stall);
        fetch_state_e st_s;
        if (!run) begin
            st_s = ST_IDLE;
        end else if (stall) begin
            st_s = ST_HOLD;
        end else begin
            st_s = ST_REQ;
        end
        return st_s;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Core-control and instruction-memory signals of the fetch sequencer.
interface pc_fetch_ctrl_if #(
    parameter int unsigned PC_W = 8
);
    logic            run;
    logic            stall;
    logic            branch_valid;
    logic [PC_W-1:0] branch_target;
    logic            fetch_req;
    logic [PC_W-1:0] fetch_addr;
    logic            fetch_ack;
    logic            instr_valid;
    logic [PC_W-1:0] instr_pc;
    logic [PC_W-1:0] pc;
    logic            busy;

    modport master (
        input  run, stall, branch_valid, branch_target, fetch_ack,
        output fetch_req, fetch_addr, instr_valid, instr_pc, pc, busy
    );

    modport slave (
        output run, stall, branch_valid, branch_target, fetch_ack,
        input  fetch_req, fetch_addr, instr_valid, instr_pc, pc, busy
    );
endinterface

// File: rtl/pc_fetch_ctrl_next_sel.sv
// Next-PC selection: a fresh branch beats a pending redirect, which beats the increment.
module pc_next_sel #(
    parameter int unsigned PC_W = 8,
    parameter int unsigned STEP = 1
) (
    input  logic [PC_W-1:0] pc,
    input  logic            redirect_pend,
    input  logic [PC_W-1:0] pend_target,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] next_pc,
    output logic            squash
);
    logic [PC_W-1:0] inc_pc_s;

    // Increment wraps silently at 2^PC_W.
    assign inc_pc_s = pc + PC_W'(STEP);
    assign squash   = redirect_pend | branch_valid;
    assign next_pc  = branch_valid  ? branch_target :
                      redirect_pend ? pend_target   : inc_pc_s;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer driving a req/ack instruction-fetch port.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W     = DEF_PC_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned STEP     = DEF_STEP
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_ctrl_if.master bus
);
    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic            pend_r;
    logic [PC_W-1:0] pend_target_r;
    logic            fetch_req_r;
    logic            instr_valid_r;
    logic [PC_W-1:0] instr_pc_r;
    logic            busy_r;
    logic [PC_W-1:0] next_pc_s;
    logic            squash_s;

    pc_next_sel #(
        .PC_W (PC_W),
        .STEP (STEP)
    ) u_next_sel (
        .pc            (pc_r),
        .redirect_pend (pend_r),
        .pend_target   (pend_target_r),
        .branch_valid  (bus.branch_valid),
        .branch_target (bus.branch_target),
        .next_pc       (next_pc_s),
        .squash        (squash_s)
    );

    assign state_nxt_s = run_state(bus.run, bus.stall);

    // FSM, PC, pending redirect and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= PC_W'(RESET_PC);
            pend_r        <= 1'b0;
            pend_target_r <= {PC_W{1'b0}};
            fetch_req_r   <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_pc_r    <= {PC_W{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (bus.fetch_ack) begin
                        pc_r          <= next_pc_s;
                        instr_valid_r <= ~squash_s;
                        instr_pc_r    <= pc_r;
                        pend_r        <= 1'b0;
                        state_r       <= state_nxt_s;
                        fetch_req_r   <= (state_nxt_s == ST_REQ);
                        busy_r        <= (state_nxt_s != ST_IDLE);
                    end else begin
                        // Request stays up unchanged; a branch is only remembered.
                        instr_valid_r <= 1'b0;
                        if (bus.branch_valid) begin
                            pend_r        <= 1'b1;
                            pend_target_r <= bus.branch_target;
                        end else begin
                            pend_r        <= pend_r;
                        end
                    end
                end
                ST_IDLE, ST_HOLD: begin
                    // Nothing in flight, so a branch lands on the PC directly.
                    instr_valid_r <= 1'b0;
                    if (bus.branch_valid) begin
                        pc_r <= next_pc_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    state_r     <= state_nxt_s;
                    fetch_req_r <= (state_nxt_s == ST_REQ);
                    busy_r      <= (state_nxt_s != ST_IDLE);
                end
                default: begin
                    state_r       <= ST_IDLE;
                    pend_r        <= 1'b0;
                    fetch_req_r   <= 1'b0;
                    instr_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_req   = fetch_req_r;
    assign bus.fetch_addr  = pc_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.pc          = pc_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: default instance plus a RESET_PC=FE instance for wrap.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic rst2;
    int   n_cmp;
    int   n_err;

    pc_fetch_ctrl_if #(.PC_W(8)) bus  ();
    pc_fetch_ctrl_if #(.PC_W(8)) bus2 ();

    pc_fetch_ctrl #(.PC_W(8), .RESET_PC(0), .STEP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    pc_fetch_ctrl #(.PC_W(8), .RESET_PC(254), .STEP(1)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;  rst2 = 1'b1;
        bus.run = 1'b0;  bus.stall = 1'b0;  bus.branch_valid = 1'b0;
        bus.branch_target = 8'h00;  bus.fetch_ack = 1'b0;
        bus2.run = 1'b0; bus2.stall = 1'b0; bus2.branch_valid = 1'b0;
        bus2.branch_target = 8'h00; bus2.fetch_ack = 1'b0;
        tick();

        // Reset state
        check_eq("rst_req",    {31'd0, bus.fetch_req},   32'd0);
        check_eq("rst_pc",     {24'd0, bus.pc},          32'd0);
        check_eq("rst_busy",   {31'd0, bus.busy},        32'd0);
        check_eq("rst_ivalid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("rst_ipc",    {24'd0, bus.instr_pc},    32'd0);
        check_eq("rst2_pc",    {24'd0, bus2.pc},         32'hFE);

        // 1: run with ack every cycle
        rst = 1'b0;
        bus.run = 1'b1;
        tick();
        bus.fetch_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_req",  {31'd0, bus.fetch_req},  32'd1);
            check_eq("t1_addr", {24'd0, bus.fetch_addr}, i);
            tick();
            check_eq("t1_ivalid", {31'd0, bus.instr_valid}, 32'd1);
            check_eq("t1_ipc",    {24'd0, bus.instr_pc},    i);
        end
        // last ack with run=0 returns to IDLE
        bus.run = 1'b0;
        tick();
        check_eq("t1_idle_busy", {31'd0, bus.busy},        32'd0);
        check_eq("t1_idle_req",  {31'd0, bus.fetch_req},   32'd0);
        check_eq("t1_idle_ipc",  {24'd0, bus.instr_pc},    32'd4);
        check_eq("t1_idle_pc",   {24'd0, bus.pc},          32'd5);

        // 3: ack delayed 3 cycles at address 05
        bus.fetch_ack = 1'b0;
        bus.run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_req",    {31'd0, bus.fetch_req},   32'd1);
            check_eq("t3_addr",   {24'd0, bus.fetch_addr},  32'h05);
            check_eq("t3_ivalid", {31'd0, bus.instr_valid}, 32'd0);
            if (i < 3) tick();
        end
        bus.fetch_ack = 1'b1;
        tick();
        check_eq("t3_ack_pc",  {24'd0, bus.pc},          32'h06);
        check_eq("t3_ack_iv",  {31'd0, bus.instr_valid}, 32'd1);
        check_eq("t3_ack_ipc", {24'd0, bus.instr_pc},    32'h05);

        // 4: branch together with the ack, then pending branch while unacked
        bus.branch_valid = 1'b1; bus.branch_target = 8'h10;
        tick();
        check_eq("t4_same_iv",   {31'd0, bus.instr_valid}, 32'd0);
        check_eq("t4_same_addr", {24'd0, bus.fetch_addr},  32'h10);
        check_eq("t4_same_req",  {31'd0, bus.fetch_req},   32'd1);
        bus.fetch_ack = 1'b0; bus.branch_target = 8'h30;
        tick();
        bus.branch_target = 8'h40;
        tick();
        bus.branch_valid = 1'b0;
        check_eq("t4_pend_addr", {24'd0, bus.fetch_addr}, 32'h10);
        check_eq("t4_pend_req",  {31'd0, bus.fetch_req},  32'd1);
        bus.fetch_ack = 1'b1;
        tick();
        check_eq("t4_sq_iv",   {31'd0, bus.instr_valid}, 32'd0);
        check_eq("t4_sq_addr", {24'd0, bus.fetch_addr},  32'h40);
        tick();
        check_eq("t4_nrm_iv",  {31'd0, bus.instr_valid}, 32'd1);
        check_eq("t4_nrm_ipc", {24'd0, bus.instr_pc},    32'h40);
        check_eq("t4_nrm_pc",  {24'd0, bus.pc},          32'h41);

        // 5: stall across an ack
        bus.stall = 1'b1;
        tick();
        check_eq("t5_ipc",  {24'd0, bus.instr_pc},  32'h41);
        check_eq("t5_req",  {31'd0, bus.fetch_req}, 32'd0);
        check_eq("t5_busy", {31'd0, bus.busy},      32'd1);
        tick();  // ack while fetch_req=0 is ignored
        check_eq("t5_ign_iv", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("t5_ign_pc", {24'd0, bus.pc},          32'h42);
        bus.fetch_ack = 1'b0; bus.stall = 1'b0;
        tick();
        check_eq("t5_res_req",  {31'd0, bus.fetch_req},  32'd1);
        check_eq("t5_res_addr", {24'd0, bus.fetch_addr}, 32'h42);
        bus.run = 1'b0; bus.fetch_ack = 1'b1;
        tick();
        check_eq("t5_halt_busy", {31'd0, bus.busy},        32'd0);
        check_eq("t5_halt_iv",   {31'd0, bus.instr_valid}, 32'd1);
        check_eq("t5_halt_pc",   {24'd0, bus.pc},          32'h43);
        bus.fetch_ack = 1'b0;
        bus.branch_valid = 1'b1; bus.branch_target = 8'h80;
        tick();
        bus.branch_valid = 1'b0;
        check_eq("t5_idle_br_pc", {24'd0, bus.pc},          32'h80);
        check_eq("t5_idle_br_iv", {31'd0, bus.instr_valid}, 32'd0);

        // 6: reset mid-REQ then a late ack
        bus.run = 1'b1;
        tick();
        check_eq("t6_req_addr", {24'd0, bus.fetch_addr}, 32'h80);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_req", {31'd0, bus.fetch_req}, 32'd0);
        check_eq("t6_rst_pc",  {24'd0, bus.pc},        32'd0);
        rst = 1'b0; bus.run = 1'b0; bus.fetch_ack = 1'b1;
        tick();
        check_eq("t6_late_iv", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("t6_late_pc", {24'd0, bus.pc},          32'd0);
        bus.fetch_ack = 1'b0;

        // 2: wrap from FE
        rst2 = 1'b0;
        bus2.run = 1'b1;
        tick();
        check_eq("t2_addr_fe", {24'd0, bus2.fetch_addr}, 32'hFE);
        bus2.fetch_ack = 1'b1;
        tick();
        check_eq("t2_addr_ff", {24'd0, bus2.fetch_addr}, 32'hFF);
        check_eq("t2_ipc_fe",  {24'd0, bus2.instr_pc},   32'hFE);
        tick();
        check_eq("t2_addr_00", {24'd0, bus2.fetch_addr}, 32'h00);
        check_eq("t2_req_00",  {31'd0, bus2.fetch_req},  32'd1);
        check_eq("t2_ipc_ff",  {24'd0, bus2.instr_pc},   32'hFF);
        tick();
        check_eq("t2_ipc_00",  {24'd0, bus2.instr_pc},   32'h00);
        check_eq("t2_pc_01",   {24'd0, bus2.pc},         32'h01);
        check_eq("t2_iv",      {31'd0, bus2.instr_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
